dac_serial_rx: RTL

Receive-side decoder for the NIM+ DAC programming interface (SCLK / NSYNC / DIN). It oversamples the three serial lines on the system clock, reassembles MSB-first frames and presents each complete frame as a parallel word with a one-cycle valid strobe. Malformed frames are flagged and counted. It sits on the DAC bus as a loopback monitor, used for readback of the programmed DAC words through the parameter registers and for self-checking the DAC writer in simulation and hardware.

---
 rtl/nimplus_dac_pkg.sv | 15 +
 rtl/sync_edge.sv | 31 +++
 rtl/dac_serial_rx.sv | 117 +++++++++++
 3 files changed

// File: rtl/nimplus_dac_pkg.sv
// nimplus_dac_pkg: shared DAC frame layout, defaults and receiver state encoding.
package nimplus_dac_pkg;
  localparam int FRAME_BITS_DEF = 32;
  localparam int CNT_W_DEF = 16;
  localparam int CMD_HI = 27;
  localparam int CMD_LO = 24;
  localparam int ADDR_HI = 23;
  localparam int ADDR_LO = 20;
  localparam int DATA_HI = 19;
  localparam int DATA_LO = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, OVER} rx_state_e;
  function automatic logic [31:0] dac_frame(input logic [3:0] cmd, input logic [3:0] addr, input logic [15:0] data);
    return {4'h0, cmd, addr, data, 4'h0};
  endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchronizer plus a registered edge stage; q is aligned with the rise/fall strobes.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1_q, s2_q, s3_q, rise_q, fall_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      s3_q   <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end
  assign q = s3_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/dac_serial_rx.sv
// dac_serial_rx: oversampling DAC serial bus monitor that rebuilds MSB-first frames and counts errors.
module dac_serial_rx
  import nimplus_dac_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  dac_sclk,
  input  logic                  dac_nsync,
  input  logic                  dac_din,
  input  logic                  cnt_clear,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  err_short,
  output logic                  err_long,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  busy
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  logic sclk_unused_q, sclk_unused_rise, sclk_fall;
  logic nsync_s, nsync_rise, nsync_fall;
  logic din_s, din_unused_rise, din_unused_fall;
  rx_state_e state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d, frame_data_q, frame_data_d, shifted;
  logic frame_valid_q, frame_valid_d, err_short_q, err_short_d, err_long_q, err_long_d;
  logic long_seen_q, long_seen_d, busy_q, last;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;

  sync_edge #(.RST_VAL(1'b1)) u_sclk (.clk(clk), .reset_n(reset_n), .d(dac_sclk),
    .q(sclk_unused_q), .rise(sclk_unused_rise), .fall(sclk_fall));
  sync_edge #(.RST_VAL(1'b1)) u_nsync (.clk(clk), .reset_n(reset_n), .d(dac_nsync),
    .q(nsync_s), .rise(nsync_rise), .fall(nsync_fall));
  sync_edge #(.RST_VAL(1'b0)) u_din (.clk(clk), .reset_n(reset_n), .d(dac_din),
    .q(din_s), .rise(din_unused_rise), .fall(din_unused_fall));

  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d = shreg_q;
    frame_data_d = frame_data_q;
    long_seen_d = long_seen_q;
    frame_valid_d = 1'b0;
    err_short_d = 1'b0;
    err_long_d = 1'b0;
    shifted = {shreg_q[FRAME_BITS-2:0], din_s};
    last = bit_cnt_q == CW'(FRAME_BITS - 1);
    case (state_q)
      IDLE: if (nsync_fall) begin
        state_d = SHIFT;
        bit_cnt_d = '0;
        shreg_d = '0;
      end
      // a coincident NSYNC rise only cancels the edge if it is not the last bit
      SHIFT: if (sclk_fall && (!nsync_rise || last)) begin
        shreg_d = shifted;
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (last) begin
          frame_data_d = shifted;
          frame_valid_d = 1'b1;
          long_seen_d = 1'b0;
          state_d = nsync_rise ? IDLE : OVER;
        end
      end else if (nsync_rise) begin
        err_short_d = 1'b1;
        state_d = IDLE;
      end
      OVER: if (nsync_rise) state_d = IDLE;
      else if (sclk_fall && !nsync_s && !long_seen_q) begin
        err_long_d = 1'b1;
        long_seen_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    frame_cnt_d = cnt_clear ? '0 : frame_cnt_q + CNT_W'(frame_valid_d && !(&frame_cnt_q));
    err_cnt_d = cnt_clear ? '0 : err_cnt_q + CNT_W'((err_short_d || err_long_d) && !(&err_cnt_q));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      shreg_q <= '0;
      frame_data_q <= '0;
      frame_valid_q <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q <= 1'b0;
      long_seen_q <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q <= shreg_d;
      frame_data_q <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      err_short_q <= err_short_d;
      err_long_q <= err_long_d;
      long_seen_q <= long_seen_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q <= err_cnt_d;
      busy_q <= state_d != IDLE;
    end
  end

  assign frame_data = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign err_short = err_short_q;
  assign err_long = err_long_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt = err_cnt_q;
  assign busy = busy_q;
endmodule
